// File: rtl/buffer_store_fcweight_banked.sv
`default_nettype none
// ============================================================================
// Module   : buffer_store_fcweight_banked
// Desc     : Banked FC weight store. Streams in LANES weights per beat and
//            returns one output channel's full weight vector per read.
//            Optional input checksum: define FCW_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module buffer_store_fcweight_banked #(
  parameter int BW    = 8,
  parameter int SIZE  = 5,
  parameter int CI    = 12,
  parameter int CO    = 10,
  parameter int LANES = 1,
  localparam int BANK  = CI * SIZE * SIZE,
  localparam int DEPTH = CO * BANK,
  localparam int BEATS = DEPTH / LANES,
  localparam int SW    = (CO > 1) ? $clog2(CO) : 1,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int KW    = BW + $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  global_rst_n,
  input  logic                  rst_processEnd,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [LANES*BW-1:0]   i_data,
  input  logic                  i_rd_en,
  input  logic [SW-1:0]         i_sel,
  output logic [BANK*BW-1:0]    o_data,
  output logic                  o_valid,
  output logic [CW-1:0]         o_cnt,
  output logic                  o_empty,
  output logic                  o_full,
  input  logic [KW-1:0]         i_checksum,
  output logic                  o_cksum_err
);

  localparam int OW = (BANK > 1) ? $clog2(BANK) : 1;

  generate
    if (BANK % LANES != 0) begin : g_lanes_check
      $error("LANES must divide CI*SIZE*SIZE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic                 valid_q, valid_d;
  logic [BANK*BW-1:0]   data_q, data_d;
  logic [SW-1:0]        wr_bank_q, wr_bank_d;
  logic [OW-1:0]        wr_off_q, wr_off_d;
  logic [BANK*BW-1:0]   rd_vec;
  logic [BW-1:0]        mem_q [CO][BANK];

  logic accept;
  logic last_beat;
  logic rd_fire;

  assign o_ready   = (state_q != S_FULL);
  assign accept    = i_valid && o_ready && !rst_processEnd;
  assign last_beat = accept && (cnt_q == CW'(DEPTH - LANES));
  assign rd_fire   = i_rd_en && (state_q == S_FULL) && !rst_processEnd;

  // Out-of-range selects read as zero rather than aliasing a real bank.
  always_comb begin
    rd_vec = '0;
    if ({1'b0, i_sel} < (SW+1)'(CO)) begin
      for (int k = 0; k < BANK; k++) begin
        rd_vec[k*BW +: BW] = mem_q[i_sel][OW'(k)];
      end
    end
  end

  // LANES divides BANK, so a beat never straddles two banks and the write
  // pointer can be tracked as (bank, offset) without any division.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_bank_d = wr_bank_q;
    wr_off_d  = wr_off_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    if (rst_processEnd) begin
      state_d   = S_EMPTY;
      cnt_d     = '0;
      wr_bank_d = '0;
      wr_off_d  = '0;
      data_d    = '0;
    end else begin
      if (accept) begin
        cnt_d   = cnt_q + CW'(LANES);
        state_d = (last_beat || BEATS == 1) ? S_FULL : S_LOAD;
        if (wr_off_q == OW'(BANK - LANES)) begin
          wr_off_d  = '0;
          wr_bank_d = wr_bank_q + 1'b1;
        end else begin
          wr_off_d  = wr_off_q + OW'(LANES);
        end
      end
      if (rd_fire) begin
        valid_d = 1'b1;
        data_d  = rd_vec;
      end
    end
    empty_d = (cnt_d == '0);
    full_d  = (state_d == S_FULL);
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q   <= S_EMPTY;
      cnt_q     <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      wr_bank_q <= '0;
      wr_off_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      wr_bank_q <= wr_bank_d;
      wr_off_q  <= wr_off_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int l = 0; l < LANES; l++) begin
        mem_q[wr_bank_q][wr_off_q + OW'(l)] <= i_data[l*BW +: BW];
      end
    end
  end

  assign o_cnt   = cnt_q;
  assign o_empty = empty_q;
  assign o_full  = full_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;

`ifdef FCW_CHECKSUM_EN
  logic [KW-1:0] acc_q, acc_d;
  logic          err_q, err_d;

  // The comparison uses the sum including the final beat.
  always_comb begin
    acc_d = acc_q;
    err_d = err_q;
    if (rst_processEnd) begin
      acc_d = '0;
      err_d = 1'b0;
    end else if (accept) begin
      for (int l = 0; l < LANES; l++) begin
        acc_d = acc_d + {{(KW-BW){i_data[l*BW+BW-1]}}, i_data[l*BW +: BW]};
      end
      if (last_beat && (acc_d != i_checksum)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end

  assign o_cksum_err = err_q;
`else
  logic unused_checksum;
  assign unused_checksum = ^i_checksum;
  assign o_cksum_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_buffer_store_fcweight_banked.sv
`default_nettype none
// Bench for buffer_store_fcweight_banked: table-driven read checks plus a
// scoreboard of expected read vectors and per-cycle status prediction.
module tb_buffer_store_fcweight_banked;

  localparam int BW    = 8;
  localparam int SIZE  = 5;
  localparam int CI    = 12;
  localparam int CO    = 10;
  localparam int L     = 1;
  localparam int BANK  = CI * SIZE * SIZE;
  localparam int DEPTH = CO * BANK;
  localparam int SW    = $clog2(CO);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int KW    = BW + $clog2(DEPTH);
  localparam int VW    = BANK * BW;
`ifdef FCW_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pe = 1'b0;
  logic            i_valid = 1'b0;
  logic [L*BW-1:0] i_data = '0;
  logic            i_rd_en = 1'b0;
  logic [SW-1:0]   i_sel = '0;
  logic [KW-1:0]   i_checksum = '0;
  logic            o_ready, o_valid, o_empty, o_full, o_cksum_err;
  logic [VW-1:0]   o_data;
  logic [CW-1:0]   o_cnt;

  buffer_store_fcweight_banked #(
    .BW(BW), .SIZE(SIZE), .CI(CI), .CO(CO), .LANES(L)
  ) dut (
    .clk           (clk),
    .global_rst_n  (rst_n),
    .rst_processEnd(pe),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_data        (i_data),
    .i_rd_en       (i_rd_en),
    .i_sel         (i_sel),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_cnt         (o_cnt),
    .o_empty       (o_empty),
    .o_full        (o_full),
    .i_checksum    (i_checksum),
    .o_cksum_err   (o_cksum_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] data;
    int            due;
  } sb_t;

  typedef struct {
    int        sel;
    int        elem;
    logic [7:0] val;
  } rdv_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            exp_cnt = 0;
  logic          exp_err = 1'b0;
  logic [KW-1:0] acc = '0;
  logic [VW-1:0] last_data = '0;
  logic [BW-1:0] model [DEPTH];
  sb_t           sbq[$];
  rdv_t          tab[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chkv(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    int idx;
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      idx = 0;
      for (int k = 0; k < BANK; k++) begin
        if (act[k*BW +: BW] !== req[k*BW +: BW]) begin
          idx = k;
          break;
        end
      end
      $display("FAIL %s: element %0d got %0h, want %0h (cycle %0d)",
               name, idx, act[idx*BW +: BW], req[idx*BW +: BW], cyc);
    end
  endtask

  function automatic logic [VW-1:0] bank_vec(input int sel);
    logic [VW-1:0] v;
    v = '0;
    if (sel < CO) begin
      for (int k = 0; k < BANK; k++) v[k*BW +: BW] = model[sel*BANK + k];
    end
    return v;
  endfunction

  function automatic logic [BW-1:0] wgt(input int mode, input int idx);
    case (mode)
      0:       return BW'(idx % 128);
      1:       return BW'((idx * 7 + 3) % 256);
      default: return 8'hFF;
    endcase
  endfunction

  task automatic check_outputs();
    sb_t e;
    chk("cnt", 64'(o_cnt), 64'(exp_cnt));
    chk("full", 64'(o_full), 64'(exp_cnt == DEPTH));
    chk("empty", 64'(o_empty), 64'(exp_cnt == 0));
    chk("ready", 64'(o_ready), 64'(exp_cnt != DEPTH));
    chk("cksum_err", 64'(o_cksum_err), 64'(exp_err));
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("rd_valid", 64'(o_valid), 64'd1);
      chkv("rd_data", o_data, e.data);
      last_data = e.data;
    end else begin
      chk("rd_valid", 64'(o_valid), 64'd0);
      chkv("data_hold", o_data, last_data);
    end
  endtask

  // Drive one cycle, predict the DUT's reaction at the edge, then check.
  task automatic cycle(input logic v, input logic [L*BW-1:0] d, input logic rd,
                       input int sel, input logic clr);
    logic was_full;
    sb_t  e;
    i_valid = v;
    i_data  = d;
    i_rd_en = rd;
    i_sel   = SW'(sel);
    pe      = clr;
    was_full = (exp_cnt == DEPTH);
    @(posedge clk);
    cyc++;
    if (clr) begin
      exp_cnt   = 0;
      acc       = '0;
      exp_err   = 1'b0;
      last_data = '0;
    end else begin
      if (v && !was_full) begin
        for (int l = 0; l < L; l++) begin
          model[exp_cnt + l] = d[l*BW +: BW];
          acc = acc + {{(KW-BW){d[l*BW+BW-1]}}, d[l*BW +: BW]};
        end
        exp_cnt += L;
        if (exp_cnt == DEPTH && acc != i_checksum) exp_err = CK;
      end
      if (rd && was_full) begin
        e.data = bank_vec(sel);
        e.due  = cyc;
        sbq.push_back(e);
      end
    end
    #1;
    check_outputs();
  endtask

  // Idle cycles in toggle mode also issue a read, which must be ignored.
  task automatic load(input int mode, input bit toggle, input int stop_at);
    int guard;
    logic [L*BW-1:0] d;
    guard = 0;
    while (exp_cnt < stop_at && guard < 4 * DEPTH) begin
      guard++;
      if (toggle && (guard % 2 == 0)) begin
        cycle(1'b0, '1, 1'b1, 2, 1'b0);
      end else begin
        for (int l = 0; l < L; l++) d[l*BW +: BW] = wgt(mode, exp_cnt + l);
        cycle(1'b1, d, 1'b0, 0, 1'b0);
      end
    end
    if (guard >= 4 * DEPTH) chk("load_timeout", 64'(exp_cnt), 64'(stop_at));
  endtask

  initial begin
    tab[0] = '{0, 0, 8'd0};
    tab[1] = '{9, 299, 8'd55};
    tab[2] = '{3, 0, 8'd4};
    tab[3] = '{12, 0, 8'd0};
    tab[4] = '{1, 5, 8'd49};
    tab[5] = '{5, 127, 8'd91};
    tab[6] = '{9, 0, 8'd12};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", 64'(o_cnt), 64'd0);
    chk("rst_empty", 64'(o_empty), 64'd1);
    chk("rst_full", 64'(o_full), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chkv("rst_data", o_data, '0);
    chk("rst_cksum_err", 64'(o_cksum_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous load, weight[n] = n mod 128.
    load(0, 1'b0, DEPTH);
    chk("load1_full", 64'(o_full), 64'd1);

    // Back-to-back table reads.
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, '0, 1'b1, tab[i].sel, 1'b0);
      chk("tab_valid", 64'(o_valid), 64'd1);
      chk("tab_elem", 64'(o_data[tab[i].elem*BW +: BW]), 64'(tab[i].val));
    end
    cycle(1'b0, '0, 1'b0, 0, 1'b0);

    // Beat while FULL is ignored; bank 9 unchanged.
    cycle(1'b1, 8'h7F, 1'b0, 0, 1'b0);
    cycle(1'b0, '0, 1'b1, 9, 1'b0);
    chk("full_beat_ignored", 64'(o_data[299*BW +: BW]), 64'd55);

    // Mid-load clear with a colliding beat, then full toggling reload.
    cycle(1'b0, '0, 1'b0, 0, 1'b1);
    load(1, 1'b1, 1500);
    cycle(1'b1, 8'h11, 1'b0, 0, 1'b1);
    cycle(1'b0, '0, 1'b1, 0, 1'b0);
    load(1, 1'b1, DEPTH);
    cycle(1'b0, '0, 1'b1, 3, 1'b0);
    chk("reload_b3_e0", 64'(o_data[7:0]), 64'd159);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, $urandom_range(0, 15), 1'b0);

    // Async reset while a read result is on the outputs.
    cycle(1'b0, '0, 1'b1, 2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(o_valid), 64'd0);
    chkv("arst_data", o_data, '0);
    chk("arst_cnt", 64'(o_cnt), 64'd0);
    chk("arst_ready", 64'(o_ready), 64'd1);
    sbq.delete();
    exp_cnt   = 0;
    acc       = '0;
    exp_err   = 1'b0;
    last_data = '0;
    @(negedge clk);
    i_rd_en = 1'b0;
    rst_n   = 1'b1;

    // Checksum: matching sum, then off-by-one, sticky until clear.
    i_checksum = KW'(-3000);
    load(2, 1'b0, DEPTH);
    cycle(1'b0, '0, 1'b1, 4, 1'b0);
    chk("cksum_ok", 64'(o_cksum_err), 64'd0);
    cycle(1'b0, '0, 1'b0, 0, 1'b1);
    i_checksum = KW'(-2999);
    load(2, 1'b0, DEPTH);
    chk("cksum_bad", 64'(o_cksum_err), 64'(CK));
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, i, 1'b0);
    cycle(1'b0, '0, 1'b0, 0, 1'b1);
    chk("cksum_cleared", 64'(o_cksum_err), 64'd0);
    cycle(1'b0, '0, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/buffer_store_fcweight_banked.md
Name: buffer_store_fcweight_banked

Overview:
Parametrised successor to the FC-layer weight store. Accepts weights as a valid/ready stream of LANES weights per beat and stores them as CO banks, each holding CI*SIZE*SIZE weights. Once full, it returns one output channel's complete weight vector per read request, so the FC layer processes one output neuron at a time instead of a single flat bus of every weight. It sits between the weight loader and the FC MAC array.

Parameters:
BW, 8, signed weight width.
SIZE, 5, kernel side; each input channel contributes SIZE*SIZE weights.
CI, 12, input channels.
CO, 10, output channels (number of banks).
LANES, 1, weights per input beat; must divide CI*SIZE*SIZE (elaboration error otherwise).
Derived, local: BANK = CI*SIZE*SIZE; DEPTH = CO*BANK; BEATS = DEPTH/LANES; SW = clog2(CO) (minimum 1); CW = clog2(DEPTH+1); KW = BW+clog2(DEPTH).

Ports:
clk  in  1  clock; all logic on the rising edge.
global_rst_n  in  1  asynchronous active-low reset.
rst_processEnd  in  1  synchronous clear at end of an inference.
i_valid  in  1  input beat valid.
o_ready  out  1  buffer accepts a beat.
i_data  in  LANES*BW  weights; lane 0 in the LSBs.
i_rd_en  in  1  read request.
i_sel  in  SW  output-channel bank to read.
o_data  out  BANK*BW  weight vector; element k at [k*BW +: BW].
o_valid  out  1  one-cycle pulse: o_data updated.
o_cnt  out  CW  weights stored so far.
o_empty  out  1  no weights stored.
o_full  out  1  all DEPTH weights stored.
i_checksum  in  KW  expected signed weight sum (FCW_CHECKSUM_EN).
o_cksum_err  out  1  checksum mismatch, sticky.

Behaviour:
- Clock and reset: one clock, clk; global_rst_n is asynchronous and active-low. Reset forces: state EMPTY, o_cnt=0, o_empty=1, o_full=0, o_ready=1, o_valid=0, o_data=0, o_cksum_err=0. Storage array is not reset.
- States:
  - EMPTY: o_cnt=0. An accepted beat moves to LOAD, or to FULL if BEATS==1.
  - LOAD: accepts beats. Accepting the last beat (o_cnt+LANES==DEPTH) moves to FULL.
  - FULL: holds until rst_processEnd.
- o_ready = 1 in EMPTY and LOAD, 0 in FULL; purely a function of state.
- A beat is accepted when i_valid && o_ready. Lane l is written to linear index o_cnt+l. Bank = index/BANK; bank offset = index%BANK. o_cnt advances by LANES the same edge.
- i_valid while in FULL: ignored, no overflow, o_cnt stays at DEPTH.
- Status outputs are registered:
  - o_full rises the cycle after the last beat is accepted.
  - o_empty falls the cycle after the first beat is accepted.
  - o_cnt is never written past DEPTH.
- Read path:
  - In FULL, i_rd_en samples i_sel. On the next edge, o_data = bank i_sel and o_valid=1 for one cycle. Latency is 1.
  - Back-to-back reads every cycle are allowed, one result per cycle.
  - i_sel >= CO: o_data = 0, o_valid still pulses.
  - i_rd_en outside FULL: ignored, o_valid stays 0, o_data holds.
  - o_data holds between reads.
- rst_processEnd: synchronous. Highest priority over accept and read in the same cycle. Returns every output to its reset value next edge; storage is untouched. A mid-load clear discards the partial load; the next accepted beat writes index 0.
- Async reset mid-operation: immediate return to reset values.

Optional Feature:
Macro FCW_CHECKSUM_EN.
- Defined:
  - A KW-bit signed accumulator sums every accepted weight, sign-extended.
  - On the edge where o_full rises, o_cksum_err is set if accumulator != i_checksum. i_checksum must be stable while the last beat is accepted.
  - o_cksum_err is sticky until rst_processEnd or reset; the accumulator clears with them.
- Not defined: no accumulator; o_cksum_err tied 0; i_checksum ignored. Ports remain, so the interface is identical.

Test Plan:
- Load with defaults (LANES=1), weight[n] = n mod 128, i_valid held high -> 3000 beats accepted, o_full=1 on cycle 3001, o_ready=0, o_cnt=3000.
- After that load, read i_sel=0, 9, 3 on consecutive cycles -> o_valid pulses on 3 consecutive cycles. Bank 3 element 0 = weight[900] = 4 (900 mod 128); bank 9 element 299 = weight[2999] = 55.
- LANES=4, i_valid toggling 1/0 -> 750 accepted beats, lane order preserved. Extra beat with 0x7F while FULL -> ignored, o_cnt stays 3000.
- rst_processEnd asserted at o_cnt=1500 in the same cycle as i_valid -> beat dropped, o_cnt=0, o_empty=1. Full reload then reads correct new data.
- i_rd_en while LOAD -> no o_valid. i_sel=12 in FULL -> o_valid=1, o_data=0. global_rst_n pulsed low mid-read -> o_valid=0, o_data=0 immediately.
- FCW_CHECKSUM_EN, all weights=-1, i_checksum=-3000 -> o_cksum_err=0. Repeat with i_checksum=-2999 -> o_cksum_err=1 with o_full, held until rst_processEnd.
